// File: rtl/dnc_pkg.sv
// dnc_pkg: shared fixed-point constants, FSM states and Q-format helpers for the DNC write weighting.
package dnc_pkg;
  localparam int DW = 64;
  localparam int CW = 64;
  localparam int FW = 32;
  localparam logic [DW-1:0] ONE = DW'(1) << FW;
  typedef enum logic [2:0] {STARTER, INPUT, MULT, SCALE, OUTPUT} state_t;
  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] x);
    return x > ONE ? ONE : x;
  endfunction
  // Sum the two products before shifting so truncation happens once, then saturate to ONE.
  function automatic logic [DW-1:0] fx_mac(input logic [DW-1:0] x0, y0, x1, y1);
    logic [2*DW-1:0] p;
    p = ((2*DW)'(x0) * (2*DW)'(y0) + (2*DW)'(x1) * (2*DW)'(y1)) >> FW;
    return p > (2*DW)'(ONE) ? ONE : p[DW-1:0];
  endfunction
endpackage

// File: rtl/dnc_fixed_multiplier.sv
// dnc_fixed_multiplier: registered unsigned Q-format multiply-accumulate q = sat((x0*y0 + x1*y1) >> FW).
module dnc_fixed_multiplier
  import dnc_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] y0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] y1,
  output logic [DW-1:0] q
);
  always_ff @(posedge CLK)
    q <= !RST ? '0 : fx_mac(x0, y0, x1, y1);
endmodule

// File: rtl/dnc_write_weighting.sv
// dnc_write_weighting: streams w_w[i] = g_w * (g_a*a[i] + (1-g_a)*c[i]) in unsigned Q-format.
module dnc_write_weighting
  import dnc_pkg::*;
#(
  parameter int DATA_SIZE       = DW,
  parameter int CONTROL_SIZE    = CW,
  parameter int FRACTIONAL_SIZE = FW,
  parameter int N               = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    GA_IN,
  input  logic [DATA_SIZE-1:0]    GW_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
  input  logic                    A_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    A_IN,
  output logic                    A_OUT_ENABLE,
  input  logic                    C_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    C_IN,
  output logic                    C_OUT_ENABLE,
  output logic                    W_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    W_OUT
);
  localparam logic [CONTROL_SIZE-1:0] N_MAX = CONTROL_SIZE'(N);
  state_t state;
  logic [DATA_SIZE-1:0] ga, gw, a_q, c_q, blend, w;
  logic [CONTROL_SIZE-1:0] size_n, index;
  logic have_a, have_c;
  // The multipliers run every cycle; the FSM only samples them once their operands have settled.
  dnc_fixed_multiplier u_blend (
    .CLK(CLK), .RST(RST), .x0(ga), .y0(a_q), .x1(ONE - ga), .y1(c_q), .q(blend)
  );
  dnc_fixed_multiplier u_scale (
    .CLK(CLK), .RST(RST), .x0(gw), .y0(blend), .x1('0), .y1('0), .q(w)
  );
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= STARTER;
      READY        <= 1'b0;
      A_OUT_ENABLE <= 1'b0;
      C_OUT_ENABLE <= 1'b0;
      W_OUT_ENABLE <= 1'b0;
      W_OUT        <= '0;
      ga           <= '0;
      gw           <= '0;
      a_q          <= '0;
      c_q          <= '0;
      size_n       <= '0;
      index        <= '0;
      have_a       <= 1'b0;
      have_c       <= 1'b0;
    end else begin
      READY        <= 1'b0;
      A_OUT_ENABLE <= 1'b0;
      C_OUT_ENABLE <= 1'b0;
      W_OUT_ENABLE <= 1'b0;
      case (state)
        STARTER: if (START) begin
          ga     <= clamp(GA_IN);
          gw     <= clamp(GW_IN);
          size_n <= SIZE_N_IN > N_MAX ? N_MAX : SIZE_N_IN;
          index  <= '0;
          have_a <= 1'b0;
          have_c <= 1'b0;
          READY  <= SIZE_N_IN == '0;
          state  <= SIZE_N_IN == '0 ? STARTER : INPUT;
        end
        INPUT: begin
          if (A_IN_ENABLE) a_q <= clamp(A_IN);
          if (C_IN_ENABLE) c_q <= clamp(C_IN);
          have_a <= have_a | A_IN_ENABLE;
          have_c <= have_c | C_IN_ENABLE;
          if ((have_a | A_IN_ENABLE) && (have_c | C_IN_ENABLE)) state <= MULT;
        end
        MULT:  state <= SCALE;
        SCALE: state <= OUTPUT;
        OUTPUT: begin
          W_OUT        <= w;
          W_OUT_ENABLE <= 1'b1;
          A_OUT_ENABLE <= 1'b1;
          C_OUT_ENABLE <= 1'b1;
          have_a       <= 1'b0;
          have_c       <= 1'b0;
          index        <= index + 1'b1;
          READY        <= index == size_n - 1'b1;
          state        <= index == size_n - 1'b1 ? STARTER : INPUT;
        end
        default: state <= STARTER;
      endcase
    end
  end
endmodule

// File: tb/tb_dnc_write_weighting.sv
// tb_dnc_write_weighting: directed scenarios with hand-computed Q32 expectations for dnc_write_weighting.
module tb_dnc_write_weighting;
  localparam logic [63:0] ONE_Q = 64'h1_0000_0000;
  logic        CLK = 0, RST = 0, START = 0, READY;
  logic [63:0] GA_IN = 0, GW_IN = 0, SIZE_N_IN = 0;
  logic        A_IN_ENABLE = 0, C_IN_ENABLE = 0;
  logic [63:0] A_IN = 0, C_IN = 0;
  logic        A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE;
  logic [63:0] W_OUT;
  int passed = 0, total = 0;

  dnc_write_weighting dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .GA_IN(GA_IN), .GW_IN(GW_IN), .SIZE_N_IN(SIZE_N_IN),
    .A_IN_ENABLE(A_IN_ENABLE), .A_IN(A_IN), .A_OUT_ENABLE(A_OUT_ENABLE),
    .C_IN_ENABLE(C_IN_ENABLE), .C_IN(C_IN), .C_OUT_ENABLE(C_OUT_ENABLE),
    .W_OUT_ENABLE(W_OUT_ENABLE), .W_OUT(W_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_vec(input logic [63:0] ga, input logic [63:0] gw, input logic [63:0] n);
    GA_IN = ga;
    GW_IN = gw;
    SIZE_N_IN = n;
    START = 1;
    tick();
    START = 0;
  endtask

  task automatic pair(input logic ae, input logic [63:0] a, input logic ce, input logic [63:0] c);
    A_IN_ENABLE = ae;
    A_IN = a;
    C_IN_ENABLE = ce;
    C_IN = c;
    tick();
    A_IN_ENABLE = 0;
    C_IN_ENABLE = 0;
  endtask

  task automatic test_reset;
    RST = 0;
    tick();
    tick();
    total++;
    if ({READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE} !== 4'b0 || W_OUT !== 64'h0)
      $display("FAIL reset flags=%b w=%h expected flags=0000 w=0",
               {READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE}, W_OUT);
    else passed++;
    RST = 1;
    tick();
  endtask

  task automatic test_single;
    start_vec(ONE_Q / 2, ONE_Q, 1);
    pair(1, ONE_Q, 1, 0);
    tick();
    tick();
    total++;
    if (W_OUT_ENABLE !== 1'b0) $display("FAIL single_early en=%b expected 0", W_OUT_ENABLE);
    else passed++;
    tick();
    total++;
    if ({W_OUT_ENABLE, READY, A_OUT_ENABLE, C_OUT_ENABLE} !== 4'b1111 || W_OUT !== 64'h8000_0000)
      $display("FAIL single_out flags=%b w=%h expected flags=1111 w=80000000",
               {W_OUT_ENABLE, READY, A_OUT_ENABLE, C_OUT_ENABLE}, W_OUT);
    else passed++;
    tick();
    total++;
    if ({W_OUT_ENABLE, READY} !== 2'b00 || W_OUT !== 64'h8000_0000)
      $display("FAIL single_hold en/ready=%b w=%h expected 00 w=80000000", {W_OUT_ENABLE, READY}, W_OUT);
    else passed++;
  endtask

  task automatic test_vector;
    logic [63:0] cv[3];
    logic [63:0] ew[3];
    cv = '{ONE_Q, ONE_Q / 2, 64'h0};
    ew = '{64'h4000_0000, 64'h2000_0000, 64'h0};
    start_vec(0, ONE_Q / 4, 3);
    for (int i = 0; i < 3; i++) begin
      pair(1, ONE_Q, 1, cv[i]);
      tick();
      tick();
      total++;
      if (W_OUT_ENABLE !== 1'b0 || READY !== 1'b0)
        $display("FAIL vector_early[%0d] en=%b ready=%b expected 0 0", i, W_OUT_ENABLE, READY);
      else passed++;
      tick();
      total++;
      if (W_OUT_ENABLE !== 1'b1 || W_OUT !== ew[i] || READY !== (i == 2))
        $display("FAIL vector_out[%0d] en=%b w=%h ready=%b expected 1 w=%h ready=%b",
                 i, W_OUT_ENABLE, W_OUT, READY, ew[i], i == 2);
      else passed++;
    end
  endtask

  task automatic test_skew;
    start_vec(ONE_Q, ONE_Q, 1);
    pair(1, ONE_Q / 2, 0, 0);
    pair(1, ONE_Q / 8, 0, 0);
    for (int i = 1; i <= 3; i++) tick();
    total++;
    if (W_OUT_ENABLE !== 1'b0 || A_OUT_ENABLE !== 1'b0)
      $display("FAIL skew_wait en=%b aen=%b expected 0 0", W_OUT_ENABLE, A_OUT_ENABLE);
    else passed++;
    pair(0, 0, 1, ONE_Q);
    tick();
    tick();
    total++;
    if (W_OUT_ENABLE !== 1'b0) $display("FAIL skew_early en=%b expected 0", W_OUT_ENABLE);
    else passed++;
    tick();
    total++;
    if ({W_OUT_ENABLE, A_OUT_ENABLE, C_OUT_ENABLE, READY} !== 4'b1111 || W_OUT !== 64'h2000_0000)
      $display("FAIL skew_out flags=%b w=%h expected flags=1111 w=20000000",
               {W_OUT_ENABLE, A_OUT_ENABLE, C_OUT_ENABLE, READY}, W_OUT);
    else passed++;
  endtask

  task automatic test_clamp;
    start_vec(3 * ONE_Q, 5 * ONE_Q, 1);
    pair(1, ONE_Q, 1, 7 * ONE_Q);
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (W_OUT_ENABLE !== 1'b1 || W_OUT !== ONE_Q || READY !== 1'b1)
      $display("FAIL clamp_out en=%b w=%h ready=%b expected 1 w=%h ready=1", W_OUT_ENABLE, W_OUT, READY, ONE_Q);
    else passed++;
  endtask

  task automatic test_zero_len;
    logic seen_w, seen_r;
    seen_w = 0;
    seen_r = 0;
    start_vec(ONE_Q, ONE_Q, 0);
    total++;
    if (READY !== 1'b1 || W_OUT_ENABLE !== 1'b0)
      $display("FAIL zero_ready ready=%b en=%b expected 1 0", READY, W_OUT_ENABLE);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      pair(1, ONE_Q, 1, ONE_Q);
      seen_w |= W_OUT_ENABLE;
      seen_r |= READY;
    end
    total++;
    if (seen_w !== 1'b0 || seen_r !== 1'b0)
      $display("FAIL zero_quiet w_en_seen=%b ready_seen=%b expected 0 0", seen_w, seen_r);
    else passed++;
  endtask

  task automatic test_abort;
    logic seen;
    seen = 0;
    start_vec(ONE_Q, ONE_Q, 4);
    for (int i = 0; i < 2; i++) begin
      pair(1, ONE_Q / 2, 1, 0);
      for (int j = 0; j < 3; j++) tick();
      total++;
      if (W_OUT_ENABLE !== 1'b1 || W_OUT !== ONE_Q / 2 || READY !== 1'b0)
        $display("FAIL abort_pre[%0d] en=%b w=%h ready=%b expected 1 w=80000000 ready=0",
                 i, W_OUT_ENABLE, W_OUT, READY);
      else passed++;
    end
    RST = 0;
    tick();
    RST = 1;
    total++;
    if ({READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE} !== 4'b0 || W_OUT !== 64'h0)
      $display("FAIL abort_reset flags=%b w=%h expected flags=0000 w=0",
               {READY, A_OUT_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE}, W_OUT);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      pair(1, ONE_Q, 1, ONE_Q);
      seen |= W_OUT_ENABLE | READY;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort_quiet activity=%b expected 0", seen);
    else passed++;
    start_vec(ONE_Q, ONE_Q, 1);
    pair(1, ONE_Q / 4, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (W_OUT_ENABLE !== 1'b1 || W_OUT !== 64'h4000_0000 || READY !== 1'b1)
      $display("FAIL abort_restart en=%b w=%h ready=%b expected 1 w=40000000 ready=1", W_OUT_ENABLE, W_OUT, READY);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_vector();
    test_skew();
    test_clamp();
    test_zero_len();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
